// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RRESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr (cyclic) wins.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite slave between NREQ single-beat requesters;
// exactly one transaction in flight, response routed back to the granted requester.
module axil_master_arbiter
  import axil_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  input  logic [NREQ*DATA_W/8-1:0]   req_wstrb,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       M_AXI_AWVALID,
  input  logic                       M_AXI_AWREADY,
  output logic [ADDR_W-1:0]          M_AXI_AWADDR,
  output logic [2:0]                 M_AXI_AWPROT,
  output logic                       M_AXI_WVALID,
  input  logic                       M_AXI_WREADY,
  output logic [DATA_W-1:0]          M_AXI_WDATA,
  output logic [DATA_W/8-1:0]        M_AXI_WSTRB,
  input  logic                       M_AXI_BVALID,
  output logic                       M_AXI_BREADY,
  input  logic [1:0]                 M_AXI_BRESP,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  output logic [ADDR_W-1:0]          M_AXI_ARADDR,
  output logic [2:0]                 M_AXI_ARPROT,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY,
  input  logic [DATA_W-1:0]          M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [NREQ-1:0]     gnt_reg, gnt_next;
  logic                write_reg, write_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic                awvalid_reg, awvalid_next;
  logic                wvalid_reg, wvalid_next;
  logic                arvalid_reg, arvalid_next;
  logic                bready_reg, bready_next;
  logic                rready_reg, rready_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic [1:0]          resp_reg, resp_next;
  logic [NREQ-1:0]     grant;

  logic [ADDR_W-1:0]   addr_arr  [NREQ];
  logic [DATA_W-1:0]   wdata_arr [NREQ];
  logic [STRB_W-1:0]   wstrb_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
  end

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  // Reset gating keeps req_ready low while reset is held even if requests are pending.
  assign req_ready = (state_reg == IDLE && S_AXI_ARESETN) ? grant : '0;
  assign rsp_valid = (state_reg == DONE) ? gnt_reg : '0;
  assign rsp_rdata = rdata_reg;
  assign rsp_resp  = resp_reg;

  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_RREADY  = rready_reg;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    write_next   = write_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    arvalid_next = arvalid_reg;
    bready_next  = bready_reg;
    rready_next  = rready_reg;
    rdata_next   = rdata_reg;
    resp_next    = resp_reg;

    case (state_reg)
      IDLE: begin
        if (|grant) begin
          gnt_next = grant;
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              ptr_next   = PTR_W'(i);
              write_next = req_write[i];
              addr_next  = addr_arr[i];
              wdata_next = wdata_arr[i];
              wstrb_next = wstrb_arr[i];
            end
          end
          if (write_next) begin
            state_next   = WADDR;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RADDR;
            arvalid_next = 1'b1;
          end
        end
      end
      WADDR: begin
        // AW and W complete independently; leave once neither is still pending.
        if (awvalid_reg && M_AXI_AWREADY) awvalid_next = 1'b0;
        if (wvalid_reg && M_AXI_WREADY)   wvalid_next  = 1'b0;
        if ((!awvalid_reg || M_AXI_AWREADY) && (!wvalid_reg || M_AXI_WREADY)) begin
          state_next  = WRESP;
          bready_next = 1'b1;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          resp_next   = M_AXI_BRESP;
          rdata_next  = '0;
          bready_next = 1'b0;
          state_next  = DONE;
        end
      end
      RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RRESP;
        end
      end
      RRESP: begin
        if (M_AXI_RVALID) begin
          rdata_next  = M_AXI_RDATA;
          resp_next   = M_AXI_RRESP;
          rready_next = 1'b0;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg   <= IDLE;
      ptr_reg     <= PTR_W'(NREQ - 1);
      gnt_reg     <= '0;
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      bready_reg  <= 1'b0;
      rready_reg  <= 1'b0;
      rdata_reg   <= '0;
      resp_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      write_reg   <= write_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      arvalid_reg <= arvalid_next;
      bready_reg  <= bready_next;
      rready_reg  <= rready_next;
      rdata_reg   <= rdata_next;
      resp_reg    <= resp_next;
    end
  end

endmodule
